// File: rtl/beezip_job_arbiter_if.sv
// Handshake bundle between the requester streams, the beezip core input and the
// monitored sequence-packet output. The arbiter takes the slave side.
interface beezip_job_arbiter_if #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_W          = 256,
    parameter int SEQ_PACKET_SIZE = 4,
    parameter int ID_W            = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_delim;
    logic                       core_valid;
    logic                       core_ready;
    logic [DATA_W-1:0]          core_data;
    logic                       core_delim;
    logic                       seq_valid;
    logic                       seq_ready;
    logic [SEQ_PACKET_SIZE-1:0] seq_strb;
    logic [SEQ_PACKET_SIZE-1:0] seq_delim;
    logic [ID_W-1:0]            seq_job_id;
    logic                       seq_job_id_valid;

    modport master (
        output req_valid, req_data, req_delim, core_ready,
        output seq_valid, seq_ready, seq_strb, seq_delim,
        input  req_ready, core_valid, core_data, core_delim,
        input  seq_job_id, seq_job_id_valid
    );

    modport slave (
        input  req_valid, req_data, req_delim, core_ready,
        input  seq_valid, seq_ready, seq_strb, seq_delim,
        output req_ready, core_valid, core_data, core_delim,
        output seq_job_id, seq_job_id_valid
    );
endinterface

// File: rtl/beezip_job_arbiter.sv
// Job-level round-robin arbiter sharing one beezip core input among NUM_REQ streams,
// with an in-flight job limit and an in-order FIFO tagging returned sequence packets.
module beezip_job_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_W          = 256,
    parameter int SEQ_PACKET_SIZE = 4,
    parameter int MAX_INFLIGHT    = 4,
    parameter int ID_W            = $clog2(NUM_REQ),
    parameter int CNT_W           = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_max_inflight,
    beezip_job_arbiter_if.slave bus,
    output logic [CNT_W-1:0] inflight_cnt,
    output logic             busy,
    output logic             err
);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      fifo_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    logic [CNT_W-1:0]     eff_limit;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;
    int                   arb_idx;
    logic                 grant;
    logic                 fire_beat;
    logic                 job_end;
    logic [SEQ_PACKET_SIZE-1:0] done_vec;
    logic                 completion;
    logic                 multi_done;
    logic                 pop;
    logic [ID_W-1:0]      next_rr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign eff_limit = (cfg_max_inflight > CNT_W'(MAX_INFLIGHT)) ? CNT_W'(MAX_INFLIGHT)
                                                                 : cfg_max_inflight;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        arb_idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_found && bus.req_valid[arb_idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(arb_idx);
            end
        end
    end

    assign grant = (state == IDLE) && pick_found && (inflight_cnt < eff_limit);

    always_comb begin
        bus.core_valid = 1'b0;
        bus.core_data  = '0;
        bus.core_delim = 1'b0;
        bus.req_ready  = '0;
        if (state == STREAM) begin
            bus.core_valid          = bus.req_valid[grant_id];
            bus.core_data           = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
            bus.core_delim          = bus.req_delim[grant_id];
            bus.req_ready[grant_id] = bus.core_ready;
        end
    end

    assign fire_beat  = (state == STREAM) && bus.req_valid[grant_id] && bus.core_ready;
    assign job_end    = fire_beat && bus.req_delim[grant_id];
    assign next_rr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign done_vec   = bus.seq_strb & bus.seq_delim;
    assign completion = bus.seq_valid && bus.seq_ready && (done_vec != '0);
    assign multi_done = completion && !$onehot(done_vec);
    // A completion with nothing in flight is an underflow: flagged, never popped.
    assign pop        = completion && (inflight_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            inflight_cnt <= '0;
            head         <= '0;
            tail         <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        grant_id <= pick_id;
                        tail     <= ptr_next(tail);
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (job_end) begin
                        rr_ptr <= next_rr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                head <= ptr_next(head);
            end

            case ({grant, pop})
                2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase

            if (completion && ((inflight_cnt == '0) || multi_done)) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_mem[tail] <= pick_id;
        end
    end

    assign bus.seq_job_id_valid = (inflight_cnt != '0);
    assign bus.seq_job_id       = (inflight_cnt != '0) ? fifo_mem[head] : '0;
    assign busy                 = (state == STREAM) || (inflight_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (inflight_cnt <= CNT_W'(MAX_INFLIGHT));
        end
    end
endmodule

// File: doc/beezip_job_arbiter.md
Name: beezip_job_arbiter

Overview:
- Job-level round-robin arbiter in front of the beezip compression core; shares one core input among NUM_REQ requester streams.
- A job is a run of HASH_ISSUE_WIDTH-byte beats ending with a delim beat. Once granted, a requester keeps the core until its delim beat is accepted; jobs are never interleaved.
- Limits the number of in-flight jobs to a configured maximum.
- Tags the sequence packets returning from the core with the originating requester ID, using an in-order job-ID FIFO.

Parameters:
- NUM_REQ, 4, number of requester streams (≥2).
- DATA_W, 256, beat width in bits (HASH_ISSUE_WIDTH*8).
- SEQ_PACKET_SIZE, 4, lanes per returned sequence packet.
- MAX_INFLIGHT, 4, job-ID FIFO depth; hard cap on in-flight jobs.
- ID_W, clog2(NUM_REQ), requester ID width.
- CNT_W, clog2(MAX_INFLIGHT)+1, counter and config width.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous, active-high reset.
- cfg_max_inflight, input, CNT_W, job limit. Effective limit = min(cfg, MAX_INFLIGHT); 0 blocks new grants.
- req_valid, input, NUM_REQ, per-requester beat valid.
- req_ready, output, NUM_REQ, per-requester beat ready.
- req_data, input, NUM_REQ*DATA_W, per-requester beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_delim, input, NUM_REQ, last beat of the job.
- core_valid, output, 1, to beezip i_valid.
- core_ready, input, 1, from beezip i_ready.
- core_data, output, DATA_W, to beezip i_data.
- core_delim, output, 1, to beezip i_delim.
- seq_valid, input, 1, monitored copy of o_seq_packet_valid.
- seq_ready, input, 1, monitored copy of o_seq_packet_ready.
- seq_strb, input, SEQ_PACKET_SIZE, monitored o_seq_packet_strb.
- seq_delim, input, SEQ_PACKET_SIZE, monitored o_seq_packet_delim.
- seq_job_id, output, ID_W, requester of the job currently being returned (FIFO head).
- seq_job_id_valid, output, 1, FIFO not empty.
- inflight_cnt, output, CNT_W, number of jobs granted but not yet completed.
- busy, output, 1, high when state is STREAM or inflight_cnt != 0.
- err, output, 1, sticky protocol error.

Behaviour:
- Reset:
  - state IDLE; rr_ptr = 0; grant_id = 0.
  - inflight_cnt = 0; FIFO empty; err = 0.
  - All outputs 0: req_ready, core_valid, core_delim, seq_job_id_valid, busy.
  - Reset mid-job drops the job silently; the partially transferred job is the caller's problem.
- State IDLE:
  - core_valid = 0 and req_ready = 0.
  - If any req_valid is set and inflight_cnt < effective limit:
    - pick the first set req_valid at or after rr_ptr, wrapping modulo NUM_REQ;
    - register grant_id, push grant_id into the FIFO, increment inflight_cnt, go to STREAM.
  - Otherwise stay in IDLE.
- State STREAM:
  - Combinational pass-through, zero latency:
    - core_valid = req_valid[grant_id];
    - core_data = req_data slice for grant_id; core_delim = req_delim[grant_id];
    - req_ready[grant_id] = core_ready; all other req_ready bits = 0.
  - A beat fires when core_valid & core_ready.
  - On a fire with core_delim = 1: rr_ptr = (grant_id+1) mod NUM_REQ, go to IDLE.
  - There is always at least one IDLE cycle between jobs (1-cycle arbitration bubble).
- Job completion:
  - A packet fires when seq_valid & seq_ready.
  - Its done-vector is seq_strb & seq_delim.
  - Exactly one bit set in done-vector: pop the FIFO and decrement inflight_cnt.
  - Zero bits set: no effect.
  - More than one bit set: pop once and set err.
- Simultaneous events:
  - Grant push and completion pop in the same cycle: inflight_cnt unchanged; FIFO head and tail both advance.
  - If the FIFO was empty, the pushed entry becomes visible at the head the following cycle.
- Underflow: a completion while inflight_cnt = 0 sets err; the counter and FIFO are unchanged.
- Overflow cannot occur, because grants are gated by the limit. Assert inflight_cnt ≤ MAX_INFLIGHT.
- cfg_max_inflight is sampled every IDLE cycle.
  - Lowering it below inflight_cnt never aborts a job; it only blocks further grants until the count drops.
- seq_job_id = FIFO head entry; it is valid whenever seq_job_id_valid = 1.
- Only a job's own delim beat releases the grant; req_valid deasserting mid-job does not release it.

Test Plan:
- Requesters 0..3 each submit a 3-beat job at once, limit 4, core_ready = 1 → grants in order 0,1,2,3; each job takes 4 cycles (3 beats + 1 idle); inflight_cnt reaches 4; FIFO holds 0,1,2,3.
- Limit 2, all requesters valid, no sequence completions → exactly 2 jobs granted (IDs 0,1), then IDLE stalls with req_ready = 0; one completion with done = 0001 → inflight_cnt = 1 and requester 2 is granted the next cycle.
- core_ready toggled 1,0,1,0 during a 4-beat job from requester 1 → beats delivered in order, none duplicated, other req_ready stay 0; rr_ptr = 2 afterwards.
- Grant and completion in the same cycle with inflight_cnt = 2 → count stays 2; seq_job_id advances to the next ID.
- Completion packet with done = 0101 → err = 1 and one pop. Separately, a completion with an empty FIFO → err = 1 and inflight_cnt stays 0.
- rst asserted mid-STREAM (beat 2 of 4) → next cycle: IDLE, inflight_cnt = 0, seq_job_id_valid = 0, err = 0, rr_ptr = 0.
